// File: rtl/fetch_unit_pkg.sv
// lc3b_types: shared LC-3b word type plus the fetch sequencer's state
// encoding and program-counter constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam lc3b_word PC_RESET = 16'h0000;
    localparam lc3b_word PC_STEP  = 16'd2;

    // Sequential successor of a fetch address; 16-bit wrap, carry dropped.
    function automatic lc3b_word next_pc(input lc3b_word addr);
        return addr + PC_STEP;
    endfunction

    // Clear bit 0 so a word fetch always targets an even byte address.
    function automatic lc3b_word word_align(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-fetch memory port.
//
// Handshake: the master raises mem_read with a stable mem_address and holds
// both unchanged until the slave answers with a single-cycle mem_resp, which
// carries mem_rdata in that same cycle. mem_resp is meaningful only while
// mem_read is high; the master never issues a second read before the first
// completes.
interface fetch_unit_if;
    import lc3b_types::*;

    lc3b_word mem_address;
    logic     mem_read;
    logic     mem_resp;
    lc3b_word mem_rdata;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_resp,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc.sv
// fetch_pc: architectural program counter. Holds the PC, applies the +2
// step when a fetch completes, and lets control redirects override that
// step for the fetch that is already in flight.
module fetch_pc
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     pc_load,     // redirect strobe from control
    input  lc3b_word pc_target,   // redirect target
    input  logic     in_flight,   // fetch FSM is in REQ or DONE
    input  logic     complete,    // memory response accepted this cycle
    input  logic     leave_done,  // FSM returns to IDLE at this edge
    input  lc3b_word fetch_addr,  // address of the fetch in flight
    output lc3b_word pc
);

    // Set by a redirect that lands while a fetch is outstanding; tells the
    // completion path to keep the redirect target instead of stepping.
    logic redirect_pending;

    // PC register: redirect wins over the completion step.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (pc_load) begin
            pc <= pc_target;
        end else if (complete && !redirect_pending) begin
            pc <= next_pc(fetch_addr);
        end
    end

    // Pending-redirect flag: lives only for the duration of one fetch.
    always_ff @(posedge clk) begin
        if (reset || leave_done) begin
            redirect_pending <= 1'b0;
        end else if (pc_load && in_flight) begin
            redirect_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LC-3b instruction fetch sequencer. Issues one word read at the
// current PC, waits for the memory response, then strobes the fetched word
// into the instruction register for one cycle.
//
// Build option FETCH_ALIGN_CHECK_EN: when defined, a fetch request whose
// effective address is odd is refused with a one-cycle fault pulse (fault
// port present). When undefined, bit 0 of the fetch address is cleared and
// the fetch proceeds.
module fetch_unit
    import lc3b_types::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic               pc_load,
    input  lc3b_word           pc_target,
    fetch_unit_if.master       mem,
    output logic               ir_load,
    output lc3b_word           ir_data,
    output lc3b_word           pc_out,
    output logic               busy,
    output fetch_state_t       state_dbg
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               fault
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    lc3b_word     fetch_addr;
    lc3b_word     eff_addr;
    lc3b_word     latch_addr;
    logic         start;
    logic         complete;
    logic         refuse;

    // Address a request issued this cycle would use: a same-cycle redirect
    // takes precedence over the current PC.
    always_comb begin
        eff_addr = pc_load ? pc_target : pc_out;
`ifdef FETCH_ALIGN_CHECK_EN
        latch_addr = eff_addr;
        refuse     = eff_addr[0];
`else
        latch_addr = word_align(eff_addr);
        refuse     = 1'b0;
`endif
    end

    // Next-state and strobe decode; fetch_req is only honoured in IDLE and
    // mem_resp only in REQ.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_req && !refuse) begin
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.mem_resp) begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch address and instruction word capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr <= PC_RESET;
            ir_data    <= 16'h0000;
        end else begin
            if (start) begin
                fetch_addr <= latch_addr;
            end
            if (complete) begin
                ir_data <= mem.mem_rdata;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned request: one-cycle fault pulse, FSM stays in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_q == IDLE) && fetch_req && refuse;
        end
    end
`endif

    fetch_pc u_pc (
        .clk        (clk),
        .reset      (reset),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .in_flight  (state_q != IDLE),
        .complete   (complete),
        .leave_done (state_q == DONE),
        .fetch_addr (fetch_addr),
        .pc         (pc_out)
    );

    // All outputs decode directly from registers, so they are glitch-free
    // and stable for the whole REQ interval.
    assign mem.mem_read    = (state_q == REQ);
    assign mem.mem_address = fetch_addr;
    assign ir_load         = (state_q == DONE);
    assign busy            = (state_q != IDLE);
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized fetch transactions against a
// transaction-level model of the PC and fetched-word stream.
module tb_fetch_unit;
    import lc3b_types::*;

    logic         clk;
    logic         reset;
    logic         fetch_req;
    logic         pc_load;
    lc3b_word     pc_target;
    logic         ir_load;
    lc3b_word     ir_data;
    lc3b_word     pc_out;
    logic         busy;
    fetch_state_t state_dbg;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         fault;
`endif

    fetch_unit_if mem_bus ();

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .mem       (mem_bus),
        .ir_load   (ir_load),
        .ir_data   (ir_data),
        .pc_out    (pc_out),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fault     (fault)
`endif
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks   = 0;
    int          failures = 0;
    lc3b_word    model_pc;
    logic [15:0] exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, 16'(state_dbg), 16'(IDLE));
        chk({tag, "_mem_read"}, 16'(mem_bus.mem_read), 16'h0);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
        chk({tag, "_ir_load"}, 16'(ir_load), 16'h0);
    endtask

    // Redirect while idle: PC takes the target on the next edge.
    task automatic idle_load(input lc3b_word tgt);
        pc_load   = 1'b1;
        pc_target = tgt;
        tick();
        pc_load   = 1'b0;
        model_pc  = tgt;
        chk("idle_load_pc", pc_out, model_pc);
        chk_idle("idle_load");
    endtask

    // A memory response while no read is outstanding must be ignored.
    task automatic stray_resp;
        mem_bus.mem_resp  = 1'b1;
        mem_bus.mem_rdata = 16'($urandom);
        tick();
        mem_bus.mem_resp  = 1'b0;
        chk_idle("stray");
        chk("stray_pc", pc_out, model_pc);
    endtask

    // One complete fetch. wait_cycles = REQ cycles before the response
    // cycle; redir_at = REQ cycle index that carries a redirect (-1: none).
    task automatic fetch_txn(input int wait_cycles, input lc3b_word rdata,
                             input logic load0, input lc3b_word tgt0,
                             input int redir_at, input lc3b_word redir_tgt);
        lc3b_word eff;
        lc3b_word addr;
        lc3b_word exp_pc;
        logic     redirected;
        redirected = 1'b0;
        eff  = load0 ? tgt0 : model_pc;
        addr = eff & 16'hFFFE;
        if (load0) model_pc = tgt0;
        fetch_req = 1'b1;
        pc_load   = load0;
        pc_target = tgt0;
        tick();
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        exp_q.push_back(rdata);
        for (int c = 0; c <= wait_cycles; c++) begin
            chk("req_mem_read", 16'(mem_bus.mem_read), 16'h1);
            chk("req_mem_address", mem_bus.mem_address, addr);
            chk("req_busy", 16'(busy), 16'h1);
            chk("req_ir_load", 16'(ir_load), 16'h0);
            chk("req_pc", pc_out, model_pc);
            fetch_req = 1'($urandom_range(0, 1));
            if (c == redir_at) begin
                pc_load    = 1'b1;
                pc_target  = redir_tgt;
                redirected = 1'b1;
                model_pc   = redir_tgt;
            end
            mem_bus.mem_resp  = (c == wait_cycles);
            mem_bus.mem_rdata = (c == wait_cycles) ? rdata : 16'($urandom);
            tick();
            pc_load          = 1'b0;
            fetch_req        = 1'b0;
            mem_bus.mem_resp = 1'b0;
        end
        exp_pc = redirected ? redir_tgt : addr + 16'd2;
        chk("done_ir_load", 16'(ir_load), 16'h1);
        chk("done_ir_data", ir_data, exp_q.pop_front());
        chk("done_pc", pc_out, exp_pc);
        chk("done_mem_read", 16'(mem_bus.mem_read), 16'h0);
        chk("done_busy", 16'(busy), 16'h1);
        model_pc = exp_pc;
        tick();
        chk_idle("post");
        chk("post_ir_data", ir_data, rdata);
    endtask

    // stimulus
    initial begin
        reset             = 1'b1;
        fetch_req         = 1'b0;
        pc_load           = 1'b0;
        pc_target         = 16'h0000;
        mem_bus.mem_resp  = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        model_pc          = 16'h0000;
        tick();
        tick();
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_ir_data", ir_data, 16'h0000);
        chk_idle("rst");
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_fault", 16'(fault), 16'h0);
`endif
        reset = 1'b0;
        tick();

        // zero-wait fetch of 0x1234 at address 0
        fetch_txn(0, 16'h1234, 1'b0, 16'h0, -1, 16'h0);
        // three wait cycles: mem_read held for four cycles
        fetch_txn(3, 16'hA5C3, 1'b0, 16'h0, -1, 16'h0);
        // wrap at the top of memory
        idle_load(16'hFFFE);
        fetch_txn(1, 16'h0F0F, 1'b0, 16'h0, -1, 16'h0);
        chk("wrap_pc", pc_out, 16'h0000);
        // redirect during REQ: address unchanged, PC takes the target
        idle_load(16'h0010);
        fetch_txn(2, 16'h7777, 1'b0, 16'h0, 1, 16'h3000);
        chk("redir_pc", pc_out, 16'h3000);
        // redirect in the response cycle itself still wins
        fetch_txn(1, 16'h1111, 1'b0, 16'h0, 1, 16'h4444);

        // reset in the middle of a fetch
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("rstmid_mem_read", 16'(mem_bus.mem_read), 16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_pc = 16'h0000;
        chk_idle("rstmid");
        chk("rstmid_pc", pc_out, 16'h0000);
        tick();
        mem_bus.mem_resp  = 1'b1;
        mem_bus.mem_rdata = 16'hBEEF;
        tick();
        mem_bus.mem_resp  = 1'b0;
        chk_idle("rstmid_late");
        chk("rstmid_late_pc", pc_out, 16'h0000);
        chk("rstmid_ir_data", ir_data, 16'h0000);
        tick();
        chk("rstmid_late2_ir_load", 16'(ir_load), 16'h0);

        // odd fetch address
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_target = 16'h0101;
        tick();
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        model_pc  = 16'h0101;
        chk("align_fault", 16'(fault), 16'h1);
        chk_idle("align");
        chk("align_pc", pc_out, 16'h0101);
        tick();
        chk("align_fault_off", 16'(fault), 16'h0);
        chk_idle("align_after");
        idle_load(16'h0100);
`else
        fetch_txn(0, 16'h2468, 1'b1, 16'h0101, -1, 16'h0);
        chk("align_pc", pc_out, 16'h0102);
`endif

        // randomized transactions
        for (int n = 0; n < 25; n++) begin
            int       w;
            int       r;
            logic     l0;
            lc3b_word t0;
            w  = int'($urandom_range(0, 4));
            r  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, w)) : -1;
            l0 = 1'($urandom_range(0, 1));
            t0 = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 3) == 0) idle_load(16'($urandom) & 16'hFFFE);
            if ($urandom_range(0, 3) == 0) stray_resp();
            fetch_txn(w, 16'($urandom), l0, t0, r, 16'($urandom) & 16'hFFFE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer sitting directly upstream of the instruction register in the LC-3b datapath. Owns the program counter, issues a word read to memory at the current PC, waits for the memory response, and presents the returned word to the instruction register with a one-cycle load strobe. Steps the PC by 2 after each fetch. Accepts branch/jump redirects from the control unit at any time.

## Interface
- No parameters; widths fixed by `lc3b_types` (word = 16 bits).
- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: control requests the next instruction; sampled only in IDLE.
- `pc_load` in 1: redirect strobe from control (branch/JMP/JSR/TRAP).
- `pc_target` in 16: redirect target, valid with `pc_load`.
- `mem_address` out 16: fetch address, driven from the registered fetch address.
- `mem_read` out 1: read request, held high until response.
- `mem_resp` in 1: memory completion, one-cycle pulse.
- `mem_rdata` in 16: read data, valid with `mem_resp`.
- `ir_load` out 1: one-cycle load strobe to the instruction register.
- `ir_data` out 16: fetched instruction word, valid while `ir_load`=1.
- `pc_out` out 16: current architectural PC (post-increment value after fetch).
- `busy` out 1: high in REQ and DONE.
- `fault` out 1: misaligned fetch pulse (exists only with `FETCH_ALIGN_CHECK_EN`).

## Operation
- States: IDLE, REQ, DONE.
- IDLE: `fetch_req`=1 -> latch `fetch_addr` <= PC (or `pc_target` if `pc_load` same cycle), go REQ.
- REQ: `mem_read`=1, `mem_address`=`fetch_addr`. On `mem_resp`=1: capture `mem_rdata` into `ir_data` register, go DONE; PC <= `fetch_addr`+2 unless a redirect is pending.
- DONE: `ir_load`=1 for exactly this cycle; go IDLE unconditionally.
- Redirect: `pc_load` in IDLE updates PC next edge. `pc_load` in REQ or DONE updates PC next edge and sets `redirect_pending`; the completion increment is discarded (redirect wins); `fetch_addr` is never changed mid-request. `redirect_pending` clears on return to IDLE.
- PC arithmetic: 16-bit modulo, 0xFFFE+2 = 0x0000, no carry out.
- `mem_resp` outside REQ ignored. `fetch_req` outside IDLE ignored (not queued).
- Reset values: PC=0x0000, state=IDLE, `mem_read`=0, `ir_load`=0, `ir_data`=0x0000, `busy`=0, `fault`=0, `redirect_pending`=0.
- Reset mid-fetch: abandons request; `mem_read` low from the cycle after the reset edge; a later `mem_resp` is ignored.

## Timing
- Cycle 0 `fetch_req`=1 in IDLE -> cycle 1 `mem_read`=1.
- Response in cycle k (k≥1) -> `ir_load`=1 in cycle k+1, `pc_out` updated in cycle k+1.
- Minimum fetch-to-load: 2 cycles (zero-wait memory); back-to-back fetch: new `fetch_req` accepted in cycle k+2.
- `mem_read` and `mem_address` registered; stable for the entire REQ state.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: on `fetch_req` in IDLE with effective fetch address bit 0 = 1, pulse `fault` for one cycle, stay IDLE, no `mem_read`, PC unchanged.
- Not defined: no `fault` port; bit 0 of `mem_address` forced to 0; fetch proceeds normally.

## Structure
- `lc3b_types`: `lc3b_word` (existing), new `fetch_state_t` enum {IDLE, REQ, DONE}, constant `PC_RESET` = 16'h0000, `PC_STEP` = 2.
- One sub-module `fetch_pc`: PC register, +2 incrementer, redirect mux and `redirect_pending` flag; FSM and memory handshake stay in `fetch_unit`.

## Test plan
- Reset, `fetch_req` cycle 0, `mem_resp` cycle 1 with 0x1234 -> `mem_address`=0x0000 cycle 1, `ir_load`=1 and `ir_data`=0x1234 cycle 2, `pc_out`=0x0002.
- 3-cycle memory wait -> `mem_read` held high 4 cycles at constant address; single `ir_load`.
- PC=0xFFFE, fetch completes -> `pc_out`=0x0000.
- `pc_load` 0x3000 during REQ at 0x0010 -> memory still reads 0x0010; after completion `pc_out`=0x3000, not 0x0012.
- Reset asserted in REQ, `mem_resp` two cycles later -> no `ir_load`, PC=0x0000, state IDLE.
- With `FETCH_ALIGN_CHECK_EN`, `pc_load`+`fetch_req` to 0x0101 in IDLE -> `fault` pulse, no `mem_read`; without macro -> `mem_address`=0x0100.
